// File: rtl/cpu_types_pkg.sv
// Shared types for the two-requester ALU arbiter: word/op types, FSM states and
// the requester count.
package cpu_types_pkg;

    localparam int unsigned ALU_REQS  = 2;
    localparam int unsigned WordWidth = 32;

    typedef logic [WordWidth-1:0] word_t;

    typedef enum logic [2:0] {
        AluAdd = 3'd0,
        AluSub = 3'd1,
        AluAnd = 3'd2,
        AluOr  = 3'd3,
        AluXor = 3'd4
    } aluop_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } arb_state_t;

    // Index of the set bit in a two-requester one-hot vector.
    function automatic logic owner_idx(logic [ALU_REQS-1:0] onehot);
        return onehot[1];
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bundle of the ALU arbiter: per-requester operands and
// handshakes, plus the shared held result and flags.
interface alu_arbiter_if;
    import cpu_types_pkg::*;

    logic   [ALU_REQS-1:0] req;
    word_t  [ALU_REQS-1:0] req_port_a;
    word_t  [ALU_REQS-1:0] req_port_b;
    aluop_t [ALU_REQS-1:0] req_alu_op;
    logic   [ALU_REQS-1:0] ack;
    logic   [ALU_REQS-1:0] gnt;
    logic   [ALU_REQS-1:0] done;
    word_t                 result;
    logic                  negative;
    logic                  overflow;
    logic                  zero;

    modport master (
        output req, req_port_a, req_port_b, req_alu_op, ack,
        input  gnt, done, result, negative, overflow, zero
    );

    modport slave (
        input  req, req_port_a, req_port_b, req_alu_op, ack,
        output gnt, done, result, negative, overflow, zero
    );

endinterface

// File: rtl/rr_picker.sv
// Round-robin winner select for two requesters: a lone requester wins, a tie
// goes to the requester that did not own the previous operation.
module rr_picker
    import cpu_types_pkg::*;
(
    input  logic [ALU_REQS-1:0] req,
    input  logic                last_owner,
    output logic [ALU_REQS-1:0] winner
);

    always_comb begin
        winner = '0;
        unique case (req)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = last_owner ? 2'b01 : 2'b10;
            default: winner = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: grant, latch operands, capture
// the ALU output one cycle later, then hold it until the owner acknowledges.
module alu_arbiter
    import cpu_types_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    alu_arbiter_if.slave bus,
    output word_t        port_a,
    output word_t        port_b,
    output aluop_t       alu_op,
    input  word_t        alu_result,
    input  logic         alu_negative,
    input  logic         alu_overflow,
    input  logic         alu_zero
);

    arb_state_t          state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_owner_q, last_owner_d;
    word_t               opa_q, opa_d;
    word_t               opb_q, opb_d;
    aluop_t              op_q, op_d;
    word_t               result_q, result_d;
    logic                neg_q, neg_d;
    logic                ovf_q, ovf_d;
    logic                zero_q, zero_d;
    logic [ALU_REQS-1:0] winner;
    logic                win_idx;

    rr_picker u_picker (
        .req        (bus.req),
        .last_owner (last_owner_q),
        .winner     (winner)
    );

    assign win_idx = owner_idx(winner);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        op_d         = op_q;
        result_d     = result_q;
        neg_d        = neg_q;
        ovf_d        = ovf_q;
        zero_d       = zero_q;
        bus.gnt      = '0;
        bus.done     = '0;

        unique case (state_q)
            IDLE: begin
                if (|winner) begin
                    bus.gnt = winner;
                    owner_d = win_idx;
                    opa_d   = bus.req_port_a[win_idx];
                    opb_d   = bus.req_port_b[win_idx];
                    op_d    = bus.req_alu_op[win_idx];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_result;
                neg_d    = alu_negative;
                ovf_d    = alu_overflow;
                zero_d   = alu_zero;
                state_d  = DONE;
            end
            DONE: begin
                bus.done[owner_q] = 1'b1;
                // Only the owner's ack releases the ALU; the other bit is ignored.
                if (bus.ack[owner_q]) begin
                    last_owner_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            opa_q        <= '0;
            opb_q        <= '0;
            op_q         <= aluop_t'(0);
            result_q     <= '0;
            neg_q        <= 1'b0;
            ovf_q        <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            op_q         <= op_d;
            result_q     <= result_d;
            neg_q        <= neg_d;
            ovf_q        <= ovf_d;
            zero_q       <= zero_d;
        end
    end

    assign port_a       = opa_q;
    assign port_b       = opb_q;
    assign alu_op       = op_q;
    assign bus.result   = result_q;
    assign bus.negative = neg_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized back-to-back traffic
// checked against a transaction-level arbitration and ALU model.
module tb_alu_arbiter;
    import cpu_types_pkg::*;

    typedef struct packed {
        word_t res;
        logic  neg;
        logic  ovf;
        logic  zer;
    } alu_out_t;

    logic     CLK = 1'b0;
    logic     RST;
    word_t    port_a, port_b, alu_result;
    aluop_t   alu_op;
    logic     alu_negative, alu_overflow, alu_zero;
    alu_out_t alu_now;
    int       n_vec = 0;
    int       n_err = 0;
    int       m_last = 1;

    alu_arbiter_if bus ();

    alu_arbiter dut (
        .CLK          (CLK),
        .RST          (RST),
        .bus          (bus),
        .port_a       (port_a),
        .port_b       (port_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_negative (alu_negative),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero)
    );

    always #5 CLK = ~CLK;

    // Reference ALU: overflow judged by comparing the exact signed sum against the 32-bit range.
    function automatic alu_out_t alu_ref(aluop_t op, word_t a, word_t b);
        alu_out_t o;
        longint   s;
        o = '0;
        s = 0;
        case (op)
            AluAdd: begin s = longint'($signed(a)) + longint'($signed(b)); o.res = a + b; end
            AluSub: begin s = longint'($signed(a)) - longint'($signed(b)); o.res = a - b; end
            AluAnd: o.res = a & b;
            AluOr:  o.res = a | b;
            AluXor: o.res = a ^ b;
            default: o.res = '0;
        endcase
        o.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        o.neg = o.res[31];
        o.zer = (o.res == 32'd0);
        return o;
    endfunction

    always_comb alu_now = alu_ref(alu_op, port_a, port_b);
    assign alu_result   = alu_now.res;
    assign alu_negative = alu_now.neg;
    assign alu_overflow = alu_now.ovf;
    assign alu_zero     = alu_now.zer;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RST = 1'b1;
        bus.req = '0;
        bus.ack = '0;
        step();
        step();
        RST = 1'b0;
        m_last = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_vec++; if ({bus.gnt, bus.done} !== 4'b0) begin n_err++;
            $display("FAIL reset_gnt_done: got %b want 0000", {bus.gnt, bus.done}); end
        n_vec++; if (bus.result !== 32'd0) begin n_err++;
            $display("FAIL reset_result: got %h want 0", bus.result); end
        n_vec++; if ({bus.negative, bus.overflow, bus.zero} !== 3'b000) begin n_err++;
            $display("FAIL reset_flags: got %b want 000", {bus.negative, bus.overflow, bus.zero}); end
        n_vec++; if ({port_a, port_b} !== 64'd0) begin n_err++;
            $display("FAIL reset_ports: got %h/%h want 0/0", port_a, port_b); end
        n_vec++; if (alu_op !== AluAdd) begin n_err++;
            $display("FAIL reset_alu_op: got %0d want 0", alu_op); end
    endtask

    task automatic test_add_single();
        bus.req_port_a[0] = 32'd5;
        bus.req_port_b[0] = 32'd7;
        bus.req_alu_op[0] = AluAdd;
        bus.req = 2'b01;
        #1;
        n_vec++; if (bus.gnt !== 2'b01) begin n_err++;
            $display("FAIL add_gnt: got %b want 01", bus.gnt); end
        step();
        bus.req = 2'b00;
        #1;
        n_vec++; if ({bus.gnt, bus.done} !== 4'b0) begin n_err++;
            $display("FAIL add_exec_idle_outs: got %b want 0000", {bus.gnt, bus.done}); end
        n_vec++; if ({port_a, port_b, alu_op} !== {32'd5, 32'd7, AluAdd}) begin n_err++;
            $display("FAIL add_alu_inputs: got %h/%h/%0d want 5/7/0", port_a, port_b, alu_op); end
        step();
        #1;
        n_vec++; if (bus.done !== 2'b01) begin n_err++;
            $display("FAIL add_done: got %b want 01", bus.done); end
        n_vec++; if (bus.result !== 32'd12) begin n_err++;
            $display("FAIL add_result: got %h want 0000000c", bus.result); end
        n_vec++; if ({bus.negative, bus.overflow, bus.zero} !== 3'b000) begin n_err++;
            $display("FAIL add_flags: got %b want 000", {bus.negative, bus.overflow, bus.zero}); end
        bus.ack = 2'b01;
        step();
        bus.ack = 2'b00;
        #1;
        n_vec++; if (bus.done !== 2'b00) begin n_err++;
            $display("FAIL add_done_clear: got %b want 00", bus.done); end
    endtask

    task automatic test_sub_overflow();
        bus.req_port_a[1] = 32'h8000_0000;
        bus.req_port_b[1] = 32'd1;
        bus.req_alu_op[1] = AluSub;
        bus.req = 2'b10;
        #1;
        n_vec++; if (bus.gnt !== 2'b10) begin n_err++;
            $display("FAIL subov_gnt: got %b want 10", bus.gnt); end
        step();
        bus.req = 2'b00;
        step();
        #1;
        n_vec++; if (bus.done !== 2'b10) begin n_err++;
            $display("FAIL subov_done: got %b want 10", bus.done); end
        n_vec++; if (bus.result !== 32'h7FFF_FFFF) begin n_err++;
            $display("FAIL subov_result: got %h want 7fffffff", bus.result); end
        n_vec++; if ({bus.negative, bus.overflow, bus.zero} !== 3'b010) begin n_err++;
            $display("FAIL subov_flags: got %b want 010", {bus.negative, bus.overflow, bus.zero}); end
        bus.ack = 2'b10;
        step();
        bus.ack = 2'b00;
    endtask

    task automatic test_sub_zero();
        bus.req_port_a[0] = 32'd9;
        bus.req_port_b[0] = 32'd9;
        bus.req_alu_op[0] = AluSub;
        bus.req = 2'b01;
        step();
        bus.req = 2'b00;
        step();
        #1;
        n_vec++; if ({bus.done, bus.result} !== {2'b01, 32'd0}) begin n_err++;
            $display("FAIL subz_done_result: got %b/%h want 01/0", bus.done, bus.result); end
        n_vec++; if ({bus.negative, bus.overflow, bus.zero} !== 3'b001) begin n_err++;
            $display("FAIL subz_flags: got %b want 001", {bus.negative, bus.overflow, bus.zero}); end
        bus.ack = 2'b01;
        step();
        bus.ack = 2'b00;
    endtask

    task automatic test_alternation();
        apply_reset();
        bus.req_port_a[0] = 32'd1; bus.req_port_b[0] = 32'd2; bus.req_alu_op[0] = AluAdd;
        bus.req_port_a[1] = 32'd3; bus.req_port_b[1] = 32'd5; bus.req_alu_op[1] = AluXor;
        bus.req = 2'b11;
        #1;
        n_vec++; if (bus.gnt !== 2'b01) begin n_err++;
            $display("FAIL alt_first_gnt: got %b want 01", bus.gnt); end
        step();
        #1;
        n_vec++; if (bus.gnt !== 2'b00) begin n_err++;
            $display("FAIL alt_exec_gnt: got %b want 00", bus.gnt); end
        step();
        bus.ack = 2'b01;
        #1;
        n_vec++; if ({bus.done, bus.result} !== {2'b01, 32'd3}) begin n_err++;
            $display("FAIL alt_first_done: got %b/%h want 01/3", bus.done, bus.result); end
        step();
        bus.ack = 2'b00;
        #1;
        n_vec++; if (bus.gnt !== 2'b10) begin n_err++;
            $display("FAIL alt_second_gnt: got %b want 10", bus.gnt); end
        step();
        step();
        bus.ack = 2'b10;
        #1;
        n_vec++; if ({bus.done, bus.result} !== {2'b10, 32'd6}) begin n_err++;
            $display("FAIL alt_second_done: got %b/%h want 10/6", bus.done, bus.result); end
        step();
        bus.ack = 2'b00;
        #1;
        n_vec++; if (bus.gnt !== 2'b01) begin n_err++;
            $display("FAIL alt_third_gnt: got %b want 01", bus.gnt); end
        step();
        bus.req = 2'b00;
        step();
        bus.ack = 2'b01;
        step();
        bus.ack = 2'b00;
    endtask

    task automatic test_foreign_ack();
        word_t a, b, exp;
        a = $urandom | 32'd1;
        b = $urandom | 32'd1;
        exp = a & b;
        bus.req_port_a[0] = a; bus.req_port_b[0] = b; bus.req_alu_op[0] = AluAnd;
        bus.req = 2'b01;
        step();
        bus.req = 2'b00;
        bus.ack = 2'b11;
        #1;
        n_vec++; if (bus.done !== 2'b00) begin n_err++;
            $display("FAIL fack_exec_done: got %b want 00", bus.done); end
        step();
        bus.ack = 2'b10;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if ({bus.done, bus.result} !== {2'b01, exp}) begin n_err++;
                $display("FAIL fack_hold[%0d]: got %b/%h want 01/%h", i, bus.done, bus.result, exp); end
            step();
        end
        bus.ack = 2'b01;
        bus.req = 2'b10;
        step();
        bus.ack = 2'b00;
        #1;
        n_vec++; if ({bus.done, bus.gnt} !== 4'b0010) begin n_err++;
            $display("FAIL fack_release: got done %b gnt %b want 00/10", bus.done, bus.gnt); end
        bus.req = 2'b00;
        step();
        step();
        n_vec++; if (bus.result !== exp) begin n_err++;
            $display("FAIL fack_result_held: got %h want %h", bus.result, exp); end
    endtask

    task automatic test_reset_mid_exec();
        bus.req_port_a[1] = 32'hF0F0_0000; bus.req_port_b[1] = 32'h0000_0F0F;
        bus.req_alu_op[1] = AluOr;
        bus.req = 2'b10;
        step();
        bus.req = 2'b00;
        #1;
        RST = 1'b1;
        #1;
        n_vec++; if ({bus.gnt, bus.done, bus.result} !== 36'd0) begin n_err++;
            $display("FAIL rst_exec_outs: got %b/%b/%h want 0", bus.gnt, bus.done, bus.result); end
        n_vec++; if ({port_a, alu_op} !== {32'd0, AluAdd}) begin n_err++;
            $display("FAIL rst_exec_alu: got %h/%0d want 0/0", port_a, alu_op); end
        step();
        RST = 1'b0;
        m_last = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (bus.done !== 2'b00) begin n_err++;
                $display("FAIL rst_no_done[%0d]: got %b want 00", i, bus.done); end
            step();
        end
        bus.req = 2'b11;
        #1;
        n_vec++; if (bus.gnt !== 2'b01) begin n_err++;
            $display("FAIL rst_tie_gnt: got %b want 01", bus.gnt); end
        step();
        bus.req = 2'b00;
        step();
        bus.ack = 2'b01;
        step();
        bus.ack = 2'b00;
    endtask

    // Back-to-back random traffic: ack in the first or later DONE cycle, with the
    // next request presented in the very next cycle.
    task automatic test_back_to_back();
        word_t      a[2], b[2];
        aluop_t     op[2];
        logic [1:0] r, oh;
        int         w, dly;
        alu_out_t   exp;
        apply_reset();
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < 2; k++) begin
                a[k]  = $urandom;
                b[k]  = ($urandom_range(0, 3) == 0) ? a[k] : $urandom;
                op[k] = aluop_t'(3'($urandom_range(0, 4)));
                bus.req_port_a[k] = a[k];
                bus.req_port_b[k] = b[k];
                bus.req_alu_op[k] = op[k];
            end
            r = 2'($urandom_range(1, 3));
            if (r == 2'b11) w = (m_last == 0) ? 1 : 0;
            else            w = (r == 2'b01) ? 0 : 1;
            oh  = (w == 0) ? 2'b01 : 2'b10;
            exp = alu_ref(op[w], a[w], b[w]);
            bus.req = r;
            bus.ack = '0;
            #1;
            n_vec++; if (bus.gnt !== oh) begin n_err++;
                $display("FAIL rnd_gnt[%0d]: got %b want %b", t, bus.gnt, oh); end
            step();
            bus.req = 2'($urandom_range(0, 3));
            bus.ack = 2'($urandom_range(0, 3));
            for (int k = 0; k < 2; k++) begin
                bus.req_port_a[k] = $urandom;
                bus.req_port_b[k] = $urandom;
            end
            #1;
            n_vec++; if ({bus.gnt, bus.done} !== 4'b0) begin n_err++;
                $display("FAIL rnd_exec[%0d]: got %b want 0000", t, {bus.gnt, bus.done}); end
            step();
            dly = $urandom_range(0, 2);
            for (int d = 0; d < dly; d++) begin
                bus.ack = 2'($urandom_range(0, 3)) & ~oh;
                #1;
                n_vec++; if ({bus.done, bus.result} !== {oh, exp.res}) begin n_err++;
                    $display("FAIL rnd_wait[%0d]: got %b/%h want %b/%h", t, bus.done, bus.result, oh, exp.res); end
                step();
            end
            bus.ack = oh | (2'($urandom_range(0, 3)) & ~oh);
            #1;
            n_vec++; if ({bus.done, bus.result, bus.negative, bus.overflow, bus.zero}
                         !== {oh, exp.res, exp.neg, exp.ovf, exp.zer}) begin n_err++;
                $display("FAIL rnd_done[%0d]: got %b/%h/%b want %b/%h/%b", t, bus.done, bus.result,
                         {bus.negative, bus.overflow, bus.zero}, oh, exp.res, {exp.neg, exp.ovf, exp.zer}); end
            step();
            m_last = w;
            bus.ack = '0;
        end
        bus.req = '0;
    endtask

    initial begin
        RST = 1'b1;
        bus.req = '0;
        bus.ack = '0;
        bus.req_port_a = '0;
        bus.req_port_b = '0;
        bus.req_alu_op = {AluAdd, AluAdd};
        test_reset();
        test_add_single();
        test_sub_overflow();
        test_sub_zero();
        test_alternation();
        test_foreign_ack();
        test_reset_mid_exec();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port req  input  [1:0]  per-requester operation request; held until matching gnt.
REQ-004 SHALL have port req_port_a  input  [1:0] word_t  operand A per requester.
REQ-005 SHALL have port req_port_b  input  [1:0] word_t  operand B per requester.
REQ-006 SHALL have port req_alu_op  input  [1:0] aluop_t  operation per requester.
REQ-007 SHALL have port ack  input  [1:0]  requester has consumed its result.
REQ-008 SHALL have port gnt  output  [1:0]  one-hot; operands of that requester sampled this edge.
REQ-009 SHALL have port done  output  [1:0]  one-hot; result valid for that requester.
REQ-010 SHALL have port result  output  word_t  held ALU result.
REQ-011 SHALL have ports negative, overflow, zero  output  1 each  held ALU flags.
REQ-012 SHALL have ports port_a, port_b  output  word_t, and alu_op  output  aluop_t, driving the shared ALU (alu_if tb-side directions).
REQ-013 SHALL have ports alu_result  input  word_t, and alu_negative, alu_overflow, alu_zero  input  1 each, from the shared ALU.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-015 SHALL, in IDLE with any req bit set, assert gnt combinationally for exactly one winner, latch that requester's operands and op into the operand registers at the edge, record the owner, and go to EXEC.
REQ-016 SHALL pick the winner round-robin: a single requesting bit wins; if both request, the bit not equal to last_owner wins.
REQ-017 SHALL drive port_a, port_b, alu_op from the operand registers in every state.
REQ-018 SHALL, in EXEC, capture alu_result and the three flags into output registers at the edge and go to DONE.
REQ-019 SHALL, in DONE, assert done[owner] only, hold result and flags stable, and stay until ack[owner]=1.
REQ-020 SHALL, on ack[owner] in DONE, set last_owner=owner and go to IDLE at the edge.
REQ-021 SHALL ignore ack from the non-owner and ack in IDLE or EXEC.
REQ-022 SHALL keep gnt=00 outside IDLE and done=00 outside DONE.
REQ-023 SHALL ignore req changes during EXEC and DONE; pending requests are re-arbitrated in IDLE.
REQ-024 SHALL meet these timings: gnt in cycle 0, done in cycle 2, earliest next gnt in cycle 3 when ack arrives in cycle 2; throughput 1 op per 3 cycles.
REQ-025 SHALL leave result and flags unchanged after DONE until the next EXEC capture.

Reset
REQ-026 SHALL, on RST, go asynchronously to IDLE with last_owner=1, so requester 0 wins the first tie.
REQ-027 SHALL reset operand registers, result, negative, overflow, zero, gnt and done to 0, and alu_op to aluop_t'(0).
REQ-028 SHALL abandon any in-flight operation when reset is asserted mid-EXEC or mid-DONE, with no done pulse afterwards.

Structure
REQ-029 SHALL define in cpu_types_pkg the constant ALU_REQS=2 and typedef arb_state_t {IDLE, EXEC, DONE}.
REQ-030 SHALL place the round-robin winner selection in sub-module rr_picker (inputs req and last_owner; output one-hot winner); the ALU itself is instantiated outside this block.

Verification
REQ-031 SHALL cover: req0 ADD 5+7 alone -> gnt=01 in cycle 0, done=01 in cycle 2, result=12, zero=0, negative=0, overflow=0.
REQ-032 SHALL cover: req1 SUB 0x80000000-1 -> done=10, result=0x7FFFFFFF, overflow=1.
REQ-033 SHALL cover: both req asserted after reset -> gnt=01 first; after ack[0], gnt=10; after ack[1] with both still requesting, gnt=01 (alternation).
REQ-034 SHALL cover: in DONE with owner 0, hold ack[1]=1 for 3 cycles -> done stays 01 and result is unchanged; then ack[0] -> IDLE next edge.
REQ-035 SHALL cover: RST asserted during EXEC -> outputs 0 immediately and state IDLE; after release, a tie grants requester 0.
REQ-036 SHALL cover: SUB 9-9 from req0 -> result=0, zero=1, negative=0.
